bp_cacc_csr_frontend: RTL and testbench
=======================================

Name: bp_cacc_csr_frontend

Overview:
Register-mapped control frontend for the coherent accelerator tile. It sits directly downstream of the tile's I/O CCE and consumes its uncached I/O command stream. It decodes loads and stores into a small CSR file (operand pointers, length, start, status, result) and returns I/O responses. It drives a start/done handshake toward the compute engine (vector dot product datapath).

Parameters:
paddr_width_p, 40, physical address width of io_cmd_addr_i
data_width_p, 64, io command/response data width; CSRs are 64 bits
len_width_p, 16, number of LSBs of the LENGTH CSR passed to the engine
payload_width_p, 32, opaque header payload echoed from command to response (lce id, etc.)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
io_cmd_wr_i  in  1  1 = uncached write, 0 = uncached read
io_cmd_addr_i  in  paddr_width_p  byte address; bits [7:0] select CSR and byte lane
io_cmd_size_i  in  2  log2 bytes: 0=1B, 1=2B, 2=4B, 3=8B
io_cmd_payload_i  in  payload_width_p  opaque, echoed in response
io_cmd_data_i  in  data_width_p  write data, LSB-aligned
io_cmd_v_i  in  1  command valid
io_cmd_ready_and_o  out  1  command ready (ready-and handshake)
io_resp_wr_o  out  1  echo of io_cmd_wr_i
io_resp_addr_o  out  paddr_width_p  echo of io_cmd_addr_i
io_resp_size_o  out  2  echo of io_cmd_size_i
io_resp_payload_o  out  payload_width_p  echo of io_cmd_payload_i
io_resp_data_o  out  data_width_p  read data, LSB-aligned; 0 for writes
io_resp_v_o  out  1  response valid
io_resp_ready_and_i  in  1  response ready
start_o  out  1  one-cycle start pulse to engine
a_ptr_o  out  paddr_width_p  operand A base address
b_ptr_o  out  paddr_width_p  operand B base address
res_ptr_o  out  paddr_width_p  result write-back address
len_o  out  len_width_p  element count
done_i  in  1  one-cycle engine-done pulse
result_i  in  data_width_p  engine result, valid with done_i

Behaviour:
- Reset (async assert, sync deassert by the environment): all CSRs are 0, state is IDLE, io_resp_v_o=0, start_o=0, io_cmd_ready_and_o=0 while reset_n_i=0. All response registers are 0.
- CSR map (addr[7:3]): 0x00 A_PTR RW; 0x08 B_PTR RW; 0x10 LENGTH RW; 0x18 RES_PTR RW; 0x20 START WO, reads 0; 0x28 STATUS (bit0 busy RO, bit1 done W1C); 0x30 RESULT RO. Other offsets are unmapped.
- Pointer outputs are the low paddr_width_p bits of their CSRs. len_o is LENGTH[len_width_p-1:0].
- FSM states are IDLE and RESP. io_cmd_ready_and_o=1 only in IDLE.
- A command is accepted on io_cmd_v_i & io_cmd_ready_and_o. The write or read takes effect that cycle, all echo fields are registered, and the FSM moves to RESP.
- In RESP, io_resp_v_o=1. Response fields hold stable until io_resp_ready_and_i=1; then the FSM returns to IDLE. Latency is one cycle from accept to response valid. Maximum throughput is one command per 2 cycles.
- Sub-word writes update only bytes [addr[2:0] +: 2^size]. The data comes from the low bytes of io_cmd_data_i.
- Reads return (CSR >> 8*addr[2:0]) masked to 2^size bytes.
- Misaligned access (addr[2:0] not a multiple of 2^size) is treated as unmapped.
- Write to START with data bit0=1 while busy=0:
  - If LENGTH[len_width_p-1:0]!=0: start_o pulses the next cycle, busy is set and done is cleared.
  - If the length is 0: there is no pulse, done is set, and RESULT is set to 0.
- Write to START while busy=1 is ignored but still answered.
- done_i sets done, clears busy and captures result_i into RESULT. done_i arriving in the same cycle as a STATUS W1C write leaves done=1 (set wins).
- done_i while busy=0 is ignored.
- Writes to A_PTR, B_PTR, RES_PTR or LENGTH while busy=1 are ignored, so engine inputs stay stable.
- Reset asserted mid-transaction drops any pending response and busy state immediately.

Optional Feature:
BP_CACC_CSR_UNMAPPED_ERR_EN
- Defined: an unmapped or misaligned access returns io_resp_data_o all-ones, and a sticky STATUS bit2 (err) is set. Writing 1 to STATUS bit2 clears it.
- Undefined: unmapped reads return 0, unmapped writes are dropped, and STATUS bit2 reads 0.
- In both cases a response is always returned.

Test Plan:
- Write A_PTR=0x8000_1000, B_PTR=0x8000_2000, LENGTH=16, then read each back. Required: data matches; each response valid 1 cycle after accept with the payload echoed.
- Write START=1. Required: start_o pulses once, STATUS reads 0x1, len_o=16. After done_i with result_i=0x2A: STATUS=0x2, RESULT=0x2A.
- Write START=1 with LENGTH=0. Required: no start_o, STATUS=0x2, RESULT=0.
- While busy, write A_PTR=0x1234 and START=1. Required: A_PTR is unchanged and no second pulse. Write STATUS=0x2 on the same cycle as done_i. Required: done stays 1.
- 1-byte write of 0xAB at 0x0003, then a 2-byte read at 0x0002. Required: returns 0xAB00 (LSB-aligned) given A_PTR=0 beforehand.
- Hold io_resp_ready_and_i=0 for 5 cycles. Required: response is held stable and io_cmd_ready_and_o=0. Access 0x40: returns 0, or all-ones with err set when BP_CACC_CSR_UNMAPPED_ERR_EN is defined. Assert reset_n_i low in RESP: io_resp_v_o drops to 0 immediately.

Source files
------------

// File: rtl/bp_cacc_csr_frontend.sv
// bp_cacc_csr_frontend
// Register-mapped control frontend for the coherent accelerator tile. It accepts
// uncached I/O commands from the tile's I/O CCE and decodes them into a small
// 64-bit CSR file. It returns one I/O response per command and drives the
// start/done handshake of the dot-product engine.
//
// CSR map (addr[7:3]):
//   0x00 A_PTR RW   0x08 B_PTR RW   0x10 LENGTH RW   0x18 RES_PTR RW
//   0x20 START WO   0x28 STATUS     0x30 RESULT RO
//
// STATUS bits: bit0 busy (RO), bit1 done (W1C), bit2 err (W1C, optional).
//
// Optional build macro: BP_CACC_CSR_UNMAPPED_ERR_EN
//   If defined, unmapped or misaligned accesses return all-ones data and set
//   the sticky STATUS.err bit.
//   If undefined, unmapped reads return 0, unmapped writes are dropped and
//   STATUS.err reads 0.
module bp_cacc_csr_frontend #(
   parameter int paddr_width_p   = 40,
   parameter int data_width_p    = 64,
   parameter int len_width_p     = 16,
   parameter int payload_width_p = 32
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,

   input  logic                       io_cmd_wr_i,
   input  logic [paddr_width_p-1:0]   io_cmd_addr_i,
   input  logic [1:0]                 io_cmd_size_i,
   input  logic [payload_width_p-1:0] io_cmd_payload_i,
   input  logic [data_width_p-1:0]    io_cmd_data_i,
   input  logic                       io_cmd_v_i,
   output logic                       io_cmd_ready_and_o,

   output logic                       io_resp_wr_o,
   output logic [paddr_width_p-1:0]   io_resp_addr_o,
   output logic [1:0]                 io_resp_size_o,
   output logic [payload_width_p-1:0] io_resp_payload_o,
   output logic [data_width_p-1:0]    io_resp_data_o,
   output logic                       io_resp_v_o,
   input  logic                       io_resp_ready_and_i,

   output logic                       start_o,
   output logic [paddr_width_p-1:0]   a_ptr_o,
   output logic [paddr_width_p-1:0]   b_ptr_o,
   output logic [paddr_width_p-1:0]   res_ptr_o,
   output logic [len_width_p-1:0]     len_o,
   input  logic                       done_i,
   input  logic [data_width_p-1:0]    result_i
);

`ifdef BP_CACC_CSR_UNMAPPED_ERR_EN
   localparam logic err_en = 1'b1;
`else
   localparam logic err_en = 1'b0;
`endif

   localparam logic [0:0] st_idle = 1'b0;
   localparam logic [0:0] st_resp = 1'b1;

   localparam logic [4:0] off_a      = 5'h00;
   localparam logic [4:0] off_b      = 5'h01;
   localparam logic [4:0] off_len    = 5'h02;
   localparam logic [4:0] off_res    = 5'h03;
   localparam logic [4:0] off_start  = 5'h04;
   localparam logic [4:0] off_status = 5'h05;
   localparam logic [4:0] off_result = 5'h06;

   // The access must start on a multiple of its own size.
   function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lane);
      logic ok;
      case (size)
         2'd0:    ok = 1'b1;
         2'd1:    ok = ~lane[0];
         2'd2:    ok = (lane[1:0] == 2'b00);
         default: ok = (lane == 3'b000);
      endcase
      return ok;
   endfunction

   // One enable bit per byte lane that the access touches.
   function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] lane);
      logic [7:0] base;
      case (size)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         2'd2:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << lane;
   endfunction

   // Expand the byte enables to a bit mask.
   function automatic logic [data_width_p-1:0] bit_en(input logic [7:0] be);
      logic [data_width_p-1:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

   // Merge lane-shifted write data into a CSR under the bit mask.
   function automatic logic [data_width_p-1:0] merge(input logic [data_width_p-1:0] old_v,
                                                      input logic [data_width_p-1:0] wd,
                                                      input logic [data_width_p-1:0] wm);
      return (old_v & ~wm) | (wd & wm);
   endfunction

   logic [0:0]                 state_r;
   logic [data_width_p-1:0]    a_ptr_r;
   logic [data_width_p-1:0]    b_ptr_r;
   logic [data_width_p-1:0]    len_r;
   logic [data_width_p-1:0]    res_ptr_r;
   logic [data_width_p-1:0]    result_r;
   logic                       busy_r;
   logic                       done_r;
   logic                       err_r;
   logic                       start_r;

   logic                       resp_wr_r;
   logic [paddr_width_p-1:0]   resp_addr_r;
   logic [1:0]                 resp_size_r;
   logic [payload_width_p-1:0] resp_payload_r;
   logic [data_width_p-1:0]    resp_data_r;

   logic                       accept;
   logic [4:0]                 cmd_off;
   logic [2:0]                 cmd_lane;
   logic                       cmd_mapped;
   logic [data_width_p-1:0]    wmask;
   logic [data_width_p-1:0]    wdata_sh;
   logic                       wr_ok;
   logic                       wr_cfg;
   logic                       start_req;
   logic                       len_nz;
   logic                       start_go;
   logic                       start_zero;
   logic                       done_evt;
   logic                       st_wr;
   logic                       clr_done;
   logic                       clr_err;
   logic                       bad_acc;
   logic [data_width_p-1:0]    status_w;
   logic [data_width_p-1:0]    csr_rd;
   logic [data_width_p-1:0]    resp_data_n;

   // Command decode: ready only in IDLE and never while reset is held.
   assign io_cmd_ready_and_o = (state_r == st_idle) & reset_n_i;
   assign accept     = io_cmd_v_i & io_cmd_ready_and_o;
   assign cmd_off    = io_cmd_addr_i[7:3];
   assign cmd_lane   = io_cmd_addr_i[2:0];
   assign cmd_mapped = is_aligned(io_cmd_size_i, cmd_lane) && (cmd_off <= off_result);
   assign wmask      = bit_en(byte_en(io_cmd_size_i, cmd_lane));
   assign wdata_sh   = io_cmd_data_i << {cmd_lane, 3'b000};

   assign wr_ok      = accept & io_cmd_wr_i & cmd_mapped;
   assign wr_cfg     = wr_ok & ~busy_r;
   assign bad_acc    = accept & ~cmd_mapped;

   // A START write only counts when it actually writes a 1 into bit 0.
   assign start_req  = wr_ok & (cmd_off == off_start) & wmask[0] & wdata_sh[0] & ~busy_r;
   assign len_nz     = |len_r[len_width_p-1:0];
   assign start_go   = start_req & len_nz;
   assign start_zero = start_req & ~len_nz;
   assign done_evt   = done_i & busy_r;

   assign st_wr      = wr_ok & (cmd_off == off_status);
   assign clr_done   = st_wr & wmask[1] & wdata_sh[1];
   assign clr_err    = st_wr & wmask[2] & wdata_sh[2];

   assign status_w   = {{(data_width_p-3){1'b0}}, err_r, done_r, busy_r};

   // CSR read mux, selected by the command offset.
   always_comb begin
      csr_rd = '0;
      case (cmd_off)
         off_a:      csr_rd = a_ptr_r;
         off_b:      csr_rd = b_ptr_r;
         off_len:    csr_rd = len_r;
         off_res:    csr_rd = res_ptr_r;
         off_status: csr_rd = status_w;
         off_result: csr_rd = result_r;
         default:    csr_rd = '0;
      endcase
   end

   // Response data: shifted/masked read, zero for writes, error pattern when unmapped.
   always_comb begin
      resp_data_n = '0;
      if (!cmd_mapped) begin
         resp_data_n = err_en ? '1 : '0;
      end else if (!io_cmd_wr_i) begin
         resp_data_n = (csr_rd >> {cmd_lane, 3'b000}) & bit_en(byte_en(io_cmd_size_i, 3'd0));
      end
   end

   // IDLE/RESP handshake FSM and the registered response fields.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r        <= st_idle;
         resp_wr_r      <= 1'b0;
         resp_addr_r    <= '0;
         resp_size_r    <= '0;
         resp_payload_r <= '0;
         resp_data_r    <= '0;
      end else begin
         case (state_r)
            st_idle: begin
               if (accept) begin
                  state_r        <= st_resp;
                  resp_wr_r      <= io_cmd_wr_i;
                  resp_addr_r    <= io_cmd_addr_i;
                  resp_size_r    <= io_cmd_size_i;
                  resp_payload_r <= io_cmd_payload_i;
                  resp_data_r    <= resp_data_n;
               end
            end
            default: begin
               if (io_resp_ready_and_i) begin
                  state_r <= st_idle;
               end
            end
         endcase
      end
   end

   // Engine configuration CSRs; frozen while the engine is busy.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         a_ptr_r   <= '0;
         b_ptr_r   <= '0;
         len_r     <= '0;
         res_ptr_r <= '0;
      end else if (wr_cfg) begin
         case (cmd_off)
            off_a:   a_ptr_r   <= merge(a_ptr_r, wdata_sh, wmask);
            off_b:   b_ptr_r   <= merge(b_ptr_r, wdata_sh, wmask);
            off_len: len_r     <= merge(len_r, wdata_sh, wmask);
            off_res: res_ptr_r <= merge(res_ptr_r, wdata_sh, wmask);
            default: ;
         endcase
      end
   end

   // Engine control: busy/done/err status, result capture and the start pulse.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         result_r <= '0;
         start_r  <= 1'b0;
      end else begin
         start_r <= start_go;

         if (done_evt) begin
            busy_r <= 1'b0;
         end else if (start_go) begin
            busy_r <= 1'b1;
         end

         // Engine completion wins over a same-cycle W1C.
         if (done_evt || start_zero) begin
            done_r <= 1'b1;
         end else if (start_go || clr_done) begin
            done_r <= 1'b0;
         end

         if (done_evt) begin
            result_r <= result_i;
         end else if (start_zero) begin
            result_r <= '0;
         end

         if (err_en && bad_acc) begin
            err_r <= 1'b1;
         end else if (clr_err) begin
            err_r <= 1'b0;
         end
      end
   end

   assign io_resp_v_o       = (state_r == st_resp);
   assign io_resp_wr_o      = resp_wr_r;
   assign io_resp_addr_o    = resp_addr_r;
   assign io_resp_size_o    = resp_size_r;
   assign io_resp_payload_o = resp_payload_r;
   assign io_resp_data_o    = resp_data_r;

   assign start_o   = start_r;
   assign a_ptr_o   = a_ptr_r[paddr_width_p-1:0];
   assign b_ptr_o   = b_ptr_r[paddr_width_p-1:0];
   assign res_ptr_o = res_ptr_r[paddr_width_p-1:0];
   assign len_o     = len_r[len_width_p-1:0];

endmodule

// File: tb/tb_bp_cacc_csr_frontend.sv
// Testbench for bp_cacc_csr_frontend: directed and randomized CSR traffic
// compared against a byte-level behavioural model of the CSR file.
module tb_bp_cacc_csr_frontend;

   localparam int PW = 40;
   localparam int DW = 64;
   localparam int LW = 16;
   localparam int YW = 32;

`ifdef BP_CACC_CSR_UNMAPPED_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_wr = 1'b0;
   logic [PW-1:0] cmd_addr = '0;
   logic [1:0]    cmd_size = '0;
   logic [YW-1:0] cmd_payload = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          cmd_v = 1'b0;
   logic          cmd_ready;
   logic          resp_wr;
   logic [PW-1:0] resp_addr;
   logic [1:0]    resp_size;
   logic [YW-1:0] resp_payload;
   logic [DW-1:0] resp_data;
   logic          resp_v;
   logic          resp_ready = 1'b0;
   logic          start;
   logic [PW-1:0] a_ptr;
   logic [PW-1:0] b_ptr;
   logic [PW-1:0] res_ptr;
   logic [LW-1:0] len;
   logic          done = 1'b0;
   logic [DW-1:0] result = '0;

   int vectors = 0;
   int miscompares = 0;
   int start_cnt = 0;

   // Behavioural model state
   logic [63:0] m_csr [0:3];
   logic [63:0] m_result;
   logic        m_busy, m_done, m_err;
   int          m_starts = 0;

   bp_cacc_csr_frontend #(
      .paddr_width_p(PW), .data_width_p(DW), .len_width_p(LW), .payload_width_p(YW)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .io_cmd_wr_i(cmd_wr), .io_cmd_addr_i(cmd_addr), .io_cmd_size_i(cmd_size),
      .io_cmd_payload_i(cmd_payload), .io_cmd_data_i(cmd_data), .io_cmd_v_i(cmd_v),
      .io_cmd_ready_and_o(cmd_ready),
      .io_resp_wr_o(resp_wr), .io_resp_addr_o(resp_addr), .io_resp_size_o(resp_size),
      .io_resp_payload_o(resp_payload), .io_resp_data_o(resp_data), .io_resp_v_o(resp_v),
      .io_resp_ready_and_i(resp_ready),
      .start_o(start), .a_ptr_o(a_ptr), .b_ptr_o(b_ptr), .res_ptr_o(res_ptr), .len_o(len),
      .done_i(done), .result_i(result)
   );

   always #5 clk = ~clk;

   // Count every cycle the start pulse is high.
   always @(negedge clk) if (start === 1'b1) start_cnt++;

   task automatic mdl_reset();
      for (int i = 0; i < 4; i++) m_csr[i] = '0;
      m_result = '0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
   endtask

   // Apply one access to the model; returns the expected response data.
   task automatic mdl_access(input logic wr, input logic [7:0] a, input logic [1:0] sz,
                             input logic [63:0] d, output logic [63:0] exp);
      int off, lane, n;
      logic [63:0] rv;
      off = int'(a[7:3]); lane = int'(a[2:0]); n = 1 << sz;
      exp = '0;
      if ((lane % n) != 0 || off > 6) begin
         if (ERR_EN) begin m_err = 1'b1; exp = '1; end
      end else if (!wr) begin
         case (off)
            0, 1, 2, 3: rv = m_csr[off];
            4:          rv = '0;
            5:          rv = {61'b0, m_err, m_done, m_busy};
            default:    rv = m_result;
         endcase
         for (int b = 0; b < n; b++) exp[8*b +: 8] = rv[8*(lane+b) +: 8];
      end else if (off <= 3) begin
         if (!m_busy) for (int b = 0; b < n; b++) m_csr[off][8*(lane+b) +: 8] = d[8*b +: 8];
      end else if (off == 4) begin
         if (lane == 0 && d[0] && !m_busy) begin
            if (m_csr[2][15:0] != 16'h0) begin m_busy = 1'b1; m_done = 1'b0; m_starts++; end
            else begin m_done = 1'b1; m_result = '0; end
         end
      end else if (off == 5 && lane == 0) begin
         if (d[1]) m_done = 1'b0;
         if (d[2]) m_err = 1'b0;
      end
   endtask

   task automatic mdl_done(input logic [63:0] res);
      if (m_busy) begin m_busy = 1'b0; m_done = 1'b1; m_result = res; end
   endtask

   // Drive one command, optionally with a same-cycle done_i, and collect the response.
   task automatic bus(input logic wr, input logic [PW-1:0] addr, input logic [1:0] sz,
                      input logic [63:0] d, input logic with_done, input logic [63:0] res,
                      output logic [63:0] rdata, output int lat, output logic echo_ok);
      logic [YW-1:0] pl;
      int w;
      pl = $urandom;
      @(negedge clk);
      cmd_wr = wr; cmd_addr = addr; cmd_size = sz; cmd_data = d; cmd_payload = pl;
      cmd_v = 1'b1; resp_ready = 1'b0;
      if (with_done) begin done = 1'b1; result = res; end
      w = 0;
      while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
      @(posedge clk); #1;
      cmd_v = 1'b0; done = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (resp_v !== 1'b1 && lat < 20);
      rdata = resp_data;
      echo_ok = (resp_wr === wr) && (resp_addr === addr) && (resp_size === sz) && (resp_payload === pl);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic pulse_done(input logic [63:0] res);
      @(negedge clk); done = 1'b1; result = res;
      @(negedge clk); done = 1'b0;
      mdl_done(res);
   endtask

   task automatic test_reset();
      logic [63:0] got, exp; int lat; logic eok;
      mdl_reset();
      repeat (3) @(negedge clk);
      vectors++; if (resp_v !== 1'b0) begin miscompares++; $display("FAIL rst_resp_v got=%b exp=0", resp_v); end
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
      vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL rst_start got=%b exp=0", start); end
      vectors++; if ({a_ptr, b_ptr, res_ptr, len} !== '0) begin miscompares++; $display("FAIL rst_outputs got=%h exp=0", {a_ptr, b_ptr, res_ptr, len}); end
      vectors++; if (resp_data !== '0) begin miscompares++; $display("FAIL rst_resp_data got=%h exp=0", resp_data); end
      reset_n = 1'b1;
      @(negedge clk);
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
      for (int off = 0; off < 7; off++) begin
         mdl_access(1'b0, 8'(off*8), 2'd3, '0, exp);
         bus(1'b0, PW'(off*8), 2'd3, '0, 1'b0, '0, got, lat, eok);
         vectors++; if (got !== exp) begin miscompares++; $display("FAIL rst_csr%0d got=%h exp=%h", off, got, exp); end
      end
   endtask

   task automatic test_csr_rw();
      logic [63:0] got, exp, d; int lat; logic eok;
      logic [7:0] addrs [3];
      logic [63:0] vals [3];
      addrs[0] = 8'h00; addrs[1] = 8'h08; addrs[2] = 8'h10;
      vals[0] = 64'h8000_1000; vals[1] = 64'h8000_2000; vals[2] = 64'd16;
      for (int i = 0; i < 3; i++) begin
         mdl_access(1'b1, addrs[i], 2'd3, vals[i], exp);
         bus(1'b1, PW'(addrs[i]), 2'd3, vals[i], 1'b0, '0, got, lat, eok);
         vectors++; if (got !== 64'h0) begin miscompares++; $display("FAIL wr_resp_data got=%h exp=0", got); end
         vectors++; if (lat !== 1 || eok !== 1'b1) begin miscompares++; $display("FAIL wr_latency_echo lat=%0d echo=%b exp lat=1 echo=1", lat, eok); end
      end
      for (int i = 0; i < 3; i++) begin
         mdl_access(1'b0, addrs[i], 2'd3, '0, exp);
         bus(1'b0, PW'(addrs[i]), 2'd3, '0, 1'b0, '0, got, lat, eok);
         vectors++; if (got !== vals[i]) begin miscompares++; $display("FAIL readback_%0d got=%h exp=%h", i, got, vals[i]); end
         vectors++; if (lat !== 1 || eok !== 1'b1) begin miscompares++; $display("FAIL rd_latency_echo lat=%0d echo=%b exp lat=1 echo=1", lat, eok); end
      end
      vectors++; if (a_ptr !== PW'(64'h8000_1000) || b_ptr !== PW'(64'h8000_2000) || len !== 16'd16) begin
         miscompares++; $display("FAIL engine_outputs got a=%h b=%h len=%0d exp a=8000001000 b=8000002000 len=16", a_ptr, b_ptr, len); end
      for (int i = 0; i < 6; i++) begin
         logic [7:0] a;
         a = 8'h18;
         d = {$urandom, $urandom};
         mdl_access(1'b1, a, 2'd3, d, exp);
         bus(1'b1, PW'(a), 2'd3, d, 1'b0, '0, got, lat, eok);
         mdl_access(1'b0, a, 2'd3, '0, exp);
         bus(1'b0, PW'(a), 2'd3, '0, 1'b0, '0, got, lat, eok);
         vectors++; if (got !== exp || res_ptr !== d[PW-1:0]) begin miscompares++; $display("FAIL res_ptr_rand got=%h out=%h exp=%h", got, res_ptr, exp); end
      end
   endtask

   task automatic test_start_done();
      logic [63:0] got, exp; int lat; logic eok;
      mdl_access(1'b1, 8'h20, 2'd3, 64'h1, exp);
      bus(1'b1, PW'(8'h20), 2'd3, 64'h1, 1'b0, '0, got, lat, eok);
      repeat (3) @(negedge clk);
      vectors++; if (start_cnt !== m_starts || m_starts !== 1) begin miscompares++; $display("FAIL start_pulse got=%0d exp=%0d", start_cnt, m_starts); end
      vectors++; if (len !== 16'd16) begin miscompares++; $display("FAIL len_out got=%0d exp=16", len); end
      mdl_access(1'b0, 8'h28, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h28), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'h1 || exp !== 64'h1) begin miscompares++; $display("FAIL status_busy got=%h exp=1", got); end
      pulse_done(64'h2A);
      mdl_access(1'b0, 8'h28, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h28), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'h2) begin miscompares++; $display("FAIL status_done got=%h exp=2", got); end
      mdl_access(1'b0, 8'h30, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h30), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'h2A) begin miscompares++; $display("FAIL result got=%h exp=2a", got); end
   endtask

   task automatic test_zero_len();
      logic [63:0] got, exp; int lat; logic eok;
      mdl_access(1'b1, 8'h28, 2'd3, 64'h2, exp);
      bus(1'b1, PW'(8'h28), 2'd3, 64'h2, 1'b0, '0, got, lat, eok);
      mdl_access(1'b0, 8'h28, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h28), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'h0) begin miscompares++; $display("FAIL w1c_done got=%h exp=0", got); end
      mdl_access(1'b1, 8'h10, 2'd3, 64'h0, exp);
      bus(1'b1, PW'(8'h10), 2'd3, 64'h0, 1'b0, '0, got, lat, eok);
      mdl_access(1'b1, 8'h20, 2'd3, 64'h1, exp);
      bus(1'b1, PW'(8'h20), 2'd3, 64'h1, 1'b0, '0, got, lat, eok);
      repeat (3) @(negedge clk);
      vectors++; if (start_cnt !== m_starts) begin miscompares++; $display("FAIL zero_len_pulse got=%0d exp=%0d", start_cnt, m_starts); end
      mdl_access(1'b0, 8'h28, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h28), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'h2) begin miscompares++; $display("FAIL zero_len_status got=%h exp=2", got); end
      mdl_access(1'b0, 8'h30, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h30), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'h0) begin miscompares++; $display("FAIL zero_len_result got=%h exp=0", got); end
   endtask

   task automatic test_busy_protect();
      logic [63:0] got, exp; int lat; logic eok;
      mdl_access(1'b1, 8'h10, 2'd3, 64'd5, exp);
      bus(1'b1, PW'(8'h10), 2'd3, 64'd5, 1'b0, '0, got, lat, eok);
      mdl_access(1'b1, 8'h20, 2'd3, 64'h1, exp);
      bus(1'b1, PW'(8'h20), 2'd3, 64'h1, 1'b0, '0, got, lat, eok);
      mdl_access(1'b1, 8'h00, 2'd3, 64'h1234, exp);
      bus(1'b1, PW'(8'h00), 2'd3, 64'h1234, 1'b0, '0, got, lat, eok);
      mdl_access(1'b1, 8'h20, 2'd3, 64'h1, exp);
      bus(1'b1, PW'(8'h20), 2'd3, 64'h1, 1'b0, '0, got, lat, eok);
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL busy_start_answered lat=%0d exp=1", lat); end
      mdl_access(1'b0, 8'h00, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h00), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'h8000_1000 || a_ptr !== PW'(64'h8000_1000)) begin miscompares++; $display("FAIL busy_a_ptr got=%h out=%h exp=80001000", got, a_ptr); end
      repeat (2) @(negedge clk);
      vectors++; if (start_cnt !== m_starts) begin miscompares++; $display("FAIL busy_pulses got=%0d exp=%0d", start_cnt, m_starts); end
      mdl_access(1'b1, 8'h28, 2'd3, 64'h2, exp);
      mdl_done(64'h55);
      bus(1'b1, PW'(8'h28), 2'd3, 64'h2, 1'b1, 64'h55, got, lat, eok);
      mdl_access(1'b0, 8'h28, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h28), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'h2) begin miscompares++; $display("FAIL done_set_wins got=%h exp=2", got); end
      mdl_access(1'b0, 8'h30, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h30), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'h55) begin miscompares++; $display("FAIL done_result got=%h exp=55", got); end
   endtask

   task automatic test_subword();
      logic [63:0] got, exp, d; int lat; logic eok;
      logic wr; logic [1:0] sz; logic [7:0] a;
      mdl_access(1'b1, 8'h00, 2'd3, 64'h0, exp);
      bus(1'b1, PW'(8'h00), 2'd3, 64'h0, 1'b0, '0, got, lat, eok);
      mdl_access(1'b1, 8'h03, 2'd0, 64'hAB, exp);
      bus(1'b1, PW'(8'h03), 2'd0, 64'hAB, 1'b0, '0, got, lat, eok);
      mdl_access(1'b0, 8'h02, 2'd1, '0, exp);
      bus(1'b0, PW'(8'h02), 2'd1, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'hAB00) begin miscompares++; $display("FAIL subword_read got=%h exp=ab00", got); end
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom);
         sz = 2'($urandom);
         a  = 8'($urandom_range(0, 63));
         d  = {$urandom, $urandom};
         if (a[7:3] == 5'h4 && ($urandom % 2) == 0) d[0] = 1'b1;
         mdl_access(wr, a, sz, d, exp);
         bus(wr, {8'($urandom), 24'h0, a}, sz, d, 1'b0, '0, got, lat, eok);
         vectors++; if (got !== exp || lat !== 1 || eok !== 1'b1) begin
            miscompares++; $display("FAIL rand_access wr=%b a=%h sz=%0d got=%h exp=%h lat=%0d echo=%b", wr, a, sz, got, exp, lat, eok); end
         if (($urandom % 4) == 0) pulse_done({$urandom, $urandom});
      end
      if (m_busy) pulse_done(64'h77);
      vectors++; if (a_ptr !== m_csr[0][PW-1:0] || b_ptr !== m_csr[1][PW-1:0] || len !== m_csr[2][LW-1:0] || res_ptr !== m_csr[3][PW-1:0]) begin
         miscompares++; $display("FAIL rand_outputs got a=%h b=%h len=%h r=%h exp a=%h b=%h len=%h r=%h", a_ptr, b_ptr, len, res_ptr, m_csr[0][PW-1:0], m_csr[1][PW-1:0], m_csr[2][LW-1:0], m_csr[3][PW-1:0]); end
      vectors++; if (start_cnt !== m_starts) begin miscompares++; $display("FAIL rand_pulses got=%0d exp=%0d", start_cnt, m_starts); end
   endtask

   task automatic test_backpressure();
      logic [63:0] exp, first; logic [YW-1:0] pl;
      mdl_access(1'b0, 8'h08, 2'd3, '0, exp);
      pl = $urandom;
      @(negedge clk);
      cmd_wr = 1'b0; cmd_addr = PW'(8'h08); cmd_size = 2'd3; cmd_payload = pl; cmd_v = 1'b1; resp_ready = 1'b0;
      @(posedge clk); #1; cmd_v = 1'b0;
      @(negedge clk);
      first = resp_data;
      vectors++; if (first !== exp) begin miscompares++; $display("FAIL bp_data got=%h exp=%h", first, exp); end
      for (int i = 0; i < 5; i++) begin
         vectors++; if (resp_v !== 1'b1 || cmd_ready !== 1'b0 || resp_data !== first || resp_payload !== pl) begin
            miscompares++; $display("FAIL bp_hold cycle=%0d v=%b rdy=%b data=%h exp v=1 rdy=0 data=%h", i, resp_v, cmd_ready, resp_data, first); end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
      @(negedge clk);
      vectors++; if (resp_v !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release v=%b rdy=%b exp v=0 rdy=1", resp_v, cmd_ready); end
   endtask

   task automatic test_unmapped();
      logic [63:0] got, exp; int lat; logic eok;
      mdl_access(1'b0, 8'h40, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h40), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== exp || got !== (ERR_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0)) begin miscompares++; $display("FAIL unmapped_read got=%h exp=%h", got, exp); end
      mdl_access(1'b0, 8'h28, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h28), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== exp || got[2] !== ERR_EN) begin miscompares++; $display("FAIL err_bit got=%h exp=%h", got, exp); end
      mdl_access(1'b1, 8'h28, 2'd3, 64'h4, exp);
      bus(1'b1, PW'(8'h28), 2'd3, 64'h4, 1'b0, '0, got, lat, eok);
      mdl_access(1'b0, 8'h0A, 2'd2, '0, exp);
      bus(1'b0, PW'(8'h0A), 2'd2, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== exp || lat !== 1) begin miscompares++; $display("FAIL misaligned got=%h exp=%h lat=%0d", got, exp, lat); end
      mdl_access(1'b0, 8'h28, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h28), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== exp) begin miscompares++; $display("FAIL err_after_misaligned got=%h exp=%h", got, exp); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] got, exp; int lat; logic eok;
      mdl_access(1'b1, 8'h10, 2'd3, 64'd3, exp);
      bus(1'b1, PW'(8'h10), 2'd3, 64'd3, 1'b0, '0, got, lat, eok);
      mdl_access(1'b1, 8'h20, 2'd3, 64'h1, exp);
      bus(1'b1, PW'(8'h20), 2'd3, 64'h1, 1'b0, '0, got, lat, eok);
      @(negedge clk);
      cmd_wr = 1'b0; cmd_addr = PW'(8'h00); cmd_size = 2'd3; cmd_v = 1'b1; resp_ready = 1'b0;
      @(posedge clk); #1; cmd_v = 1'b0;
      @(negedge clk); #2;
      reset_n = 1'b0;
      #1;
      vectors++; if (resp_v !== 1'b0 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset v=%b rdy=%b exp 0 0", resp_v, cmd_ready); end
      mdl_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      mdl_access(1'b0, 8'h28, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h28), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== 64'h0) begin miscompares++; $display("FAIL mid_reset_status got=%h exp=0", got); end
      mdl_access(1'b0, 8'h10, 2'd3, '0, exp);
      bus(1'b0, PW'(8'h10), 2'd3, '0, 1'b0, '0, got, lat, eok);
      vectors++; if (got !== exp || len !== '0) begin miscompares++; $display("FAIL mid_reset_len got=%h out=%h exp=0", got, len); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_csr_rw();
      test_start_done();
      test_zero_len();
      test_busy_protect();
      test_subword();
      test_backpressure();
      test_unmapped();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
